nz_mask_builder: RTL and testbench

- Upstream stage of the nonzero-bit detector in the sparse activation path.
- Accepts a valid/ready stream of activation words and assigns each word a 1-bit nonzero flag.
- Packs N consecutive flags into an N-bit tile mask. The mask is the detector's `data` input.
- Emits each mask with its word count, nonzero count, tile index and a last flag. A flush request closes a partial tile.

---
 rtl/nz_mask_builder_pkg.sv | 24 ++
 rtl/nz_popcount.sv | 19 +
 rtl/nz_mask_builder.sv | 114 +++++++++++
 tb/tb_nz_mask_builder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/nz_mask_builder_pkg.sv
// Shared types and defaults for the sparse activation path.
// Both the mask builder and the downstream detector use the descriptor struct.
package nz_mask_builder_pkg;

   localparam int N_DEFAULT  = 8;
   localparam int DW_DEFAULT = 16;
   localparam int TW_DEFAULT = 8;
   localparam int CNT_W      = $clog2(N_DEFAULT + 1);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   // One tile descriptor as seen on the builder output / detector input.
   typedef struct packed {
      logic [N_DEFAULT-1:0]  mask;
      logic [CNT_W-1:0]      count;
      logic [CNT_W-1:0]      nz_count;
      logic                  last;
      logic [TW_DEFAULT-1:0] tile_idx;
   } tile_desc_t;

endpackage

// File: rtl/nz_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module nz_popcount #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]               bits_i,
   output logic [$clog2(WIDTH+1)-1:0]     count_o
);

   localparam int OW = $clog2(WIDTH + 1);

   // Written as a simple accumulation; synthesis rebalances it into an adder tree.
   always_comb begin
      count_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         count_o = count_o + OW'(bits_i[i]);
      end
   end

endmodule

// File: rtl/nz_mask_builder.sv
// Packs per-word nonzero flags into N-bit tile masks and emits one descriptor
// per tile, with flush closing a partial tile.
module nz_mask_builder
   import nz_mask_builder_pkg::*;
#(
   parameter int N  = N_DEFAULT,
   parameter int DW = DW_DEFAULT,
   parameter int TW = TW_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DW-1:0]              in_data,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [N-1:0]               out_mask,
   output logic [$clog2(N+1)-1:0]     out_count,
   output logic [$clog2(N+1)-1:0]     out_nz_count,
   output logic                       out_last,
   output logic [TW-1:0]              out_tile_idx
);

   localparam int CW = $clog2(N + 1);

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [N-1:0]    mask_q;
   logic            outValid_q;
   logic [N-1:0]    outMask_q;
   logic [CW-1:0]   outCount_q;
   logic [CW-1:0]   outNz_q;
   logic            outLast_q;
   logic [TW-1:0]   outIdx_q;

   logic            accept;
   logic [N-1:0]    wordBit;
   logic [N-1:0]    mask_d;
   logic [CW-1:0]   cnt_d;
   logic            closeTile;
   logic [CW-1:0]   nzCount_d;

   assign in_ready = (state_q == FILL) || ((state_q == HOLD) && out_ready);
   assign accept   = in_valid && in_ready;

   // The working mask is cleared on entry to HOLD, so the same fill path
   // drops a word accepted during HOLD into bit 0 of the next tile.
   always_comb begin
      wordBit   = {{(N-1){1'b0}}, |in_data} << cnt_q;
      mask_d    = accept ? (mask_q | wordBit) : mask_q;
      cnt_d     = cnt_q + CW'(accept);
      closeTile = (state_q == FILL) &&
                  ((accept && (cnt_q == CW'(N-1))) || (flush && (cnt_d != '0)));
   end

   nz_popcount #(.WIDTH(N)) uPopcount (
      .bits_i  (mask_d),
      .count_o (nzCount_d)
   );

   // Tile FSM: FILL collects words, HOLD presents the descriptor until taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FILL;
         cnt_q      <= '0;
         mask_q     <= '0;
         outValid_q <= 1'b0;
         outMask_q  <= '0;
         outCount_q <= '0;
         outNz_q    <= '0;
         outLast_q  <= 1'b0;
         outIdx_q   <= '0;
      end else begin
         case (state_q)
            FILL: begin
               if (closeTile) begin
                  outMask_q  <= mask_d;
                  outCount_q <= cnt_d;
                  outNz_q    <= nzCount_d;
                  outLast_q  <= flush;
                  outValid_q <= 1'b1;
                  cnt_q      <= '0;
                  mask_q     <= '0;
                  state_q    <= HOLD;
               end else begin
                  cnt_q  <= cnt_d;
                  mask_q <= mask_d;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  outIdx_q   <= outLast_q ? '0 : outIdx_q + TW'(1);
                  outValid_q <= 1'b0;
                  cnt_q      <= cnt_d;
                  mask_q     <= mask_d;
                  state_q    <= FILL;
               end
            end
            default: begin
               state_q <= FILL;
            end
         endcase
      end
   end

   assign out_valid    = outValid_q;
   assign out_mask     = outMask_q;
   assign out_count    = outCount_q;
   assign out_nz_count = outNz_q;
   assign out_last     = outLast_q;
   assign out_tile_idx = outIdx_q;

endmodule

// File: tb/tb_nz_mask_builder.sv
// Scoreboard bench for nz_mask_builder (N=8, DW=16, TW=8): a reference model
// queues expected descriptors as words are handshaked and checks them at the output.
module tb_nz_mask_builder;
   import nz_mask_builder_pkg::*;

   localparam int N  = 8;
   localparam int DW = 16;
   localparam int TW = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   in_data;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [N-1:0]    out_mask;
   logic [CNT_W-1:0] out_count;
   logic [CNT_W-1:0] out_nz_count;
   logic            out_last;
   logic [TW-1:0]   out_tile_idx;

   int assertCount = 0;
   int failCount   = 0;

   tile_desc_t sbQ[$];
   logic       mHold;
   int         mCnt;
   logic [N-1:0]  mMask;
   logic [TW-1:0] mIdx;

   nz_mask_builder #(.N(N), .DW(DW), .TW(TW)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_mask     (out_mask),
      .out_count    (out_count),
      .out_nz_count (out_nz_count),
      .out_last     (out_last),
      .out_tile_idx (out_tile_idx)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      sbQ.delete();
      mHold = 1'b0;
      mCnt  = 0;
      mMask = '0;
      mIdx  = '0;
   endtask

   // Async reset for a couple of cycles; outputs are checked while rst is high.
   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
      #1;
      modelReset();
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_mask", out_mask, 0);
      checkOutput("rst_out_count", out_count, 0);
      checkOutput("rst_out_nz", out_nz_count, 0);
      checkOutput("rst_out_last", out_last, 0);
      checkOutput("rst_tile_idx", out_tile_idx, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // One clock: drive at negedge, sample #1 later, then advance the model.
   task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic f, input logic r);
      logic       expReady;
      logic       acc;
      tile_desc_t exp;
      tile_desc_t popped;
      @(negedge clk);
      in_valid = v; in_data = d; flush = f; out_ready = r;
      #1;
      expReady = !mHold || r;
      checkOutput("in_ready", in_ready, expReady);
      checkOutput("out_valid", out_valid, mHold);
      if (mHold && out_valid) begin
         checkOutput("sb_pending", (sbQ.size() > 0) ? 1 : 0, 1);
         if (sbQ.size() > 0) begin
            exp = sbQ[0];
            checkOutput("out_mask", out_mask, exp.mask);
            checkOutput("out_count", out_count, exp.count);
            checkOutput("out_nz_count", out_nz_count, exp.nz_count);
            checkOutput("out_last", out_last, exp.last);
            checkOutput("out_tile_idx", out_tile_idx, exp.tile_idx);
         end
      end
      acc = v && expReady;
      if (mHold) begin
         if (r) begin
            if (sbQ.size() > 0) begin
               popped = sbQ.pop_front();
               mIdx = popped.last ? '0 : mIdx + 1'b1;
            end
            mHold = 1'b0;
            mMask = '0;
            mCnt  = 0;
            if (acc) begin
               mMask[0] = |d;
               mCnt = 1;
            end
         end
      end else begin
         if (acc) begin
            mMask[mCnt] = |d;
            mCnt++;
         end
         if ((acc && mCnt == N) || (f && mCnt != 0)) begin
            exp.mask     = mMask;
            exp.count    = CNT_W'(mCnt);
            exp.nz_count = CNT_W'($countones(mMask));
            exp.last     = f;
            exp.tile_idx = mIdx;
            sbQ.push_back(exp);
            mHold = 1'b1;
            mMask = '0;
            mCnt  = 0;
         end
      end
   endtask

   logic [DW-1:0] t1Words [8] = '{16'h0000, 16'h0003, 16'h0000, 16'h0000,
                                  16'h8000, 16'h0000, 16'h0000, 16'h0001};
   logic [DW-1:0] flushWords [3] = '{16'h0005, 16'h0000, 16'h0007};

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
      doReset();

      // Directed tile with a known mask.
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, t1Words[i], 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("t1_valid", out_valid, 1);
      checkOutput("t1_mask", out_mask, 32'h92);
      checkOutput("t1_count", out_count, 8);
      checkOutput("t1_nz", out_nz_count, 3);
      checkOutput("t1_last", out_last, 0);
      checkOutput("t1_idx", out_tile_idx, 0);

      // Continuous stream of three tiles, mixed zero / nonzero words.
      doReset();
      for (int i = 0; i < 24; i++)
         applyStimulus(1'b1, ($urandom_range(0, 2) == 0) ? 16'h0000 : DW'($urandom), 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("t2_idx_last", out_tile_idx, 2);

      // Backpressure: descriptor held while words are offered, then a word lands in bit 0.
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, DW'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, DW'($urandom), 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h0001, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 16'h0000, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("t3_bit0_mask", out_mask, 32'h01);

      // Flush of a partial tile, then the tile index restarts.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, flushWords[i], 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      checkOutput("t4_mask", out_mask, 32'h05);
      checkOutput("t4_count", out_count, 3);
      checkOutput("t4_nz", out_nz_count, 2);
      checkOutput("t4_last", out_last, 1);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, DW'($urandom), 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("t4_next_idx", out_tile_idx, 0);

      // Flush on an empty tile is ignored; flush on the 8th word closes a full tile.
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);
      checkOutput("t5_no_desc", out_valid, 0);
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, DW'($urandom), 1'b0, 1'b1);
      applyStimulus(1'b1, 16'h0000, 1'b1, 1'b1);
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      checkOutput("t5_count", out_count, 8);
      checkOutput("t5_last", out_last, 1);

      // Reset mid-tile discards the partial words.
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b1);
      doReset();
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, (i == 2) ? 16'h0010 : 16'h0000, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("t6_mask", out_mask, 32'h04);
      checkOutput("t6_idx", out_tile_idx, 0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);

      checkOutput("sb_empty", sbQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
